// File: rtl/usrt_tx_ctrl.sv
// USRT transmit controller: frames words LSB-first on txd, one bit per rising
// edge of the external usrt_clk, with rts handshake, optional parity and FIFO/counter source.
//
// state  | meaning
// IDLE   | line idle; waiting for run and an available word
// START  | drive the start bit (0)
// DATA   | shift out len data bits, LSB first
// PAR    | drive the parity bit
// STOP   | drive the stop bit (1); chain the next word if one is ready
// TAIL   | drop rts; one bit-time of trailing guard
module usrt_tx_ctrl #(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 4,
    parameter int FIFO_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              usrt_clk,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        par_sel,
    input  logic              src_sel,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              ovf,
    output logic              busy,
    output logic              rts,
    output logic              txd
);

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_TAIL
    } state_t;

    logic r_sync1;
    logic r_sync2;
    logic r_sync_d;
    logic w_pedge;

    logic r_run;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic [FIFO_AW:0]   w_count_nx;
    logic               r_full;
    logic               r_empty;
    logic               r_ovf;
    logic               w_pop;
    logic               w_wr_ok;
    logic [DATA_W-1:0]  w_head;

    logic [DATA_W-1:0] r_pat;

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_rts;
    logic              w_rts_nx;
    logic              r_txd;
    logic              w_txd_nx;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  w_cnt_nx;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_word_nx;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_len_nx;
    logic [1:0]        r_par;
    logic [1:0]        w_par_nx;
    logic              w_latch;

    logic              w_avail;
    logic [LEN_W-1:0]  w_len_eff;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_src_word;
    logic              w_bit;
    logic              w_par_en;

    // Bit clock crosses into clk through a 2-FF synchroniser before edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= usrt_clk;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_pedge = r_sync2 & ~r_sync_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else if (start) begin
            r_run <= 1'b1;
        end else if (stop) begin
            r_run <= 1'b0;
        end
    end

    assign w_avail    = src_sel | ~r_empty;
    assign w_len_eff  = (len == '0 || len > LEN_MAX) ? LEN_MAX : len;
    assign w_mask     = ~({DATA_W{1'b1}} << w_len_eff);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_src_word = (src_sel ? r_pat : w_head) & w_mask;
    assign w_par_en   = (r_par == 2'b01) || (r_par == 2'b10);

    always_comb begin
        w_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (r_cnt == LEN_W'(i)) begin
                w_bit = r_word[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rts   <= 1'b0;
            r_txd   <= 1'b1;
            r_cnt   <= '0;
            r_word  <= '0;
            r_len   <= LEN_MAX;
            r_par   <= 2'b00;
        end else begin
            r_state <= w_state_nx;
            r_rts   <= w_rts_nx;
            r_txd   <= w_txd_nx;
            r_cnt   <= w_cnt_nx;
            r_word  <= w_word_nx;
            r_len   <= w_len_nx;
            r_par   <= w_par_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_rts_nx   = r_rts;
        w_txd_nx   = r_txd;
        w_cnt_nx   = r_cnt;
        w_word_nx  = r_word;
        w_len_nx   = r_len;
        w_par_nx   = r_par;
        w_latch    = 1'b0;
        if (w_pedge) begin
            case (r_state)
                S_IDLE: begin
                    if (r_run && w_avail) begin
                        w_latch    = 1'b1;
                        w_rts_nx   = 1'b1;
                        w_txd_nx   = 1'b1;
                        w_state_nx = S_START;
                    end
                end
                S_START: begin
                    w_txd_nx   = 1'b0;
                    w_cnt_nx   = '0;
                    w_state_nx = S_DATA;
                end
                S_DATA: begin
                    w_txd_nx = w_bit;
                    w_cnt_nx = r_cnt + LEN_W'(1);
                    if (r_cnt == r_len - LEN_W'(1)) begin
                        w_state_nx = w_par_en ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    // Bits above the latched length were masked off at latch time.
                    w_txd_nx   = (^r_word) ^ r_par[1];
                    w_state_nx = S_STOP;
                end
                S_STOP: begin
                    w_txd_nx = 1'b1;
                    if (r_run && w_avail) begin
                        w_latch    = 1'b1;
                        w_state_nx = S_START;
                    end else begin
                        w_state_nx = S_TAIL;
                    end
                end
                S_TAIL: begin
                    w_rts_nx   = 1'b0;
                    w_state_nx = S_IDLE;
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
        if (w_latch) begin
            w_word_nx = w_src_word;
            w_len_nx  = w_len_eff;
            w_par_nx  = par_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pat <= '0;
        end else if (w_latch && src_sel) begin
            r_pat <= r_pat + DATA_W'(1);
        end
    end

    // A pop frees a slot in the same clk, so a write alongside it is accepted even when full.
    assign w_pop   = w_latch & ~src_sel;
    assign w_wr_ok = wr_en & (~r_full | w_pop);

    always_comb begin
        w_count_nx = r_count;
        if (w_wr_ok && !w_pop) begin
            w_count_nx = r_count + (FIFO_AW+1)'(1);
        end else if (!w_wr_ok && w_pop) begin
            w_count_nx = r_count - (FIFO_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            r_count <= w_count_nx;
            r_full  <= (w_count_nx == CNT_FULL);
            r_empty <= (w_count_nx == '0);
            r_ovf   <= wr_en & r_full & ~w_pop;
        end
    end

    assign fifo_full  = r_full;
    assign fifo_empty = r_empty;
    assign ovf        = r_ovf;
    assign busy       = (r_state != S_IDLE);
    assign rts        = r_rts;
    assign txd        = r_txd;

endmodule

// File: tb/tb_usrt_tx_ctrl.sv
// Self-checking bench for usrt_tx_ctrl: expected line traces (rts,txd per bit-time)
// are built from word lists, length and parity rules, then compared with the sampled line.
module tb_usrt_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       usrt_clk = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] len = 4'd8;
    logic [1:0] par_sel = 2'b00;
    logic       src_sel = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_full;
    logic       fifo_empty;
    logic       ovf;
    logic       busy;
    logic       rts;
    logic       txd;

    usrt_tx_ctrl #(.DATA_W(8), .LEN_W(4), .FIFO_AW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .usrt_clk   (usrt_clk),
        .start      (start),
        .stop       (stop),
        .len        (len),
        .par_sel    (par_sel),
        .src_sel    (src_sel),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .ovf        (ovf),
        .busy       (busy),
        .rts        (rts),
        .txd        (txd)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_words[$];
    logic [1:0] exp_line[$];
    logic [1:0] obs_line[$];
    int         pat = 0;

    task automatic check_val(input string tag, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic pulse(input bit p_start, input bit p_stop);
        @(negedge clk);
        start = p_start;
        stop  = p_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic fifo_write(input logic [7:0] d);
        bit drop;
        drop = (model_q.size() >= 8);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (!drop) model_q.push_back(d);
        check_val("wr_ovf", ovf, int'(drop));
        check_val("wr_full", fifo_full, int'(model_q.size() == 8));
        check_val("wr_empty", fifo_empty, int'(model_q.size() == 0));
        if (drop) begin
            @(negedge clk);
            check_val("ovf_one_clk", ovf, 0);
        end
    endtask

    // One usrt_clk period; line sampled once the synchronised rise has been acted on.
    task automatic bit_time(input bit do_wr, input logic [7:0] d, output logic o_rts, output logic o_txd);
        int hi;
        int lo;
        hi = $urandom_range(6, 3);
        lo = $urandom_range(6, 3);
        @(negedge clk);
        usrt_clk = 1'b1;
        repeat (2) @(negedge clk);
        if (do_wr) begin
            wr_en   = 1'b1;
            wr_data = d;
        end
        @(negedge clk);
        if (do_wr) begin
            wr_en = 1'b0;
            check_val("pop_wr_ovf", ovf, 0);
            check_val("pop_wr_full", fifo_full, 1);
        end
        o_rts = rts;
        o_txd = txd;
        check_val("busy_vs_rts", busy, rts);
        repeat (hi - 3) @(negedge clk);
        usrt_clk = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    function automatic int eff_len(input int ln);
        return (ln == 0 || ln > 8) ? 8 : ln;
    endfunction

    function automatic int par_bits(input int ps);
        return (ps == 1 || ps == 2) ? 1 : 0;
    endfunction

    task automatic build_exp(input int ln, input int ps);
        int l;
        int mw;
        int ones;
        int b;
        l = eff_len(ln);
        exp_line.delete();
        for (int k = 0; k < exp_words.size(); k++) begin
            if (k == 0) exp_line.push_back(2'b11);
            exp_line.push_back(2'b10);
            mw   = int'(exp_words[k]) % (1 << l);
            ones = 0;
            for (int i = 0; i < l; i++) begin
                b = (mw >> i) & 1;
                ones += b;
                exp_line.push_back({1'b1, b[0]});
            end
            if (ps == 1) exp_line.push_back({1'b1, (ones % 2) == 1});
            if (ps == 2) exp_line.push_back({1'b1, (ones % 2) == 0});
            exp_line.push_back(2'b11);
        end
        exp_line.push_back(2'b01);
    endtask

    task automatic capture(input int stop_at, input int wr_at, input logic [7:0] wr_d, input int budget);
        logic r;
        logic t;
        bit   started;
        bit   done;
        int   n;
        started = 0;
        done    = 0;
        obs_line.delete();
        for (int i = 0; i < budget && !done; i++) begin
            bit_time(i == wr_at, wr_d, r, t);
            if (r) started = 1;
            if (started) obs_line.push_back({r, t});
            if (started && !r) done = 1;
            if (i == stop_at) pulse(1'b0, 1'b1);
        end
        check_val("frame_done", int'(done), 1);
        check_val("line_len", obs_line.size(), exp_line.size());
        n = (obs_line.size() < exp_line.size()) ? obs_line.size() : exp_line.size();
        for (int j = 0; j < n; j++) begin
            check_val($sformatf("line_bit%0d", j), obs_line[j], exp_line[j]);
        end
    endtask

    task automatic fifo_burst(input int ln, input int ps);
        len     = 4'(ln);
        par_sel = 2'(ps);
        src_sel = 1'b0;
        exp_words = model_q;
        build_exp(ln, ps);
        pulse(1'b1, 1'b0);
        capture(-1, -1, 8'h00, exp_line.size() + 8);
        model_q.delete();
        pulse(1'b0, 1'b1);
        check_val("burst_empty", fifo_empty, 1);
    endtask

    task automatic cnt_burst(input int ln, input int ps, input int nf);
        int f;
        len     = 4'(ln);
        par_sel = 2'(ps);
        src_sel = 1'b1;
        f = eff_len(ln) + par_bits(ps) + 2;
        exp_words.delete();
        for (int k = 0; k < nf; k++) exp_words.push_back(8'((pat + k) % 256));
        build_exp(ln, ps);
        pulse(1'b1, 1'b0);
        // stop lands on the first data bit of the last wanted frame
        capture(1 + (nf - 1) * f + 1, -1, 8'h00, exp_line.size() + 8);
        pat = (pat + nf) % 256;
        src_sel = 1'b0;
    endtask

    initial begin
        logic       r;
        logic       t;
        logic [7:0] nw;
        int         nwords;

        repeat (3) @(negedge clk);
        check_val("rst_rts", rts, 0);
        check_val("rst_txd", txd, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_ovf", ovf, 0);
        check_val("rst_empty", fifo_empty, 1);
        check_val("rst_full", fifo_full, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fifo_write(8'hA5);
        fifo_burst(8, 0);
        fifo_write(8'h35);
        fifo_burst(7, 1);
        fifo_write(8'h35);
        fifo_burst(7, 2);

        for (int k = 0; k < 3; k++) fifo_write(8'($urandom));
        fifo_burst(8, 1);

        cnt_burst(4, 0, 18);
        cnt_burst(4, 0, 5);

        for (int k = 0; k < 8; k++) fifo_write(8'($urandom));
        fifo_write(8'h5A);
        nw = 8'($urandom);
        len = 4'd8;
        par_sel = 2'b00;
        src_sel = 1'b0;
        exp_words = model_q;
        exp_words.push_back(nw);
        build_exp(8, 0);
        pulse(1'b1, 1'b0);
        capture(-1, 0, nw, exp_line.size() + 8);
        model_q.delete();
        pulse(1'b0, 1'b1);
        check_val("ovf_test_empty", fifo_empty, 1);

        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                nwords = $urandom_range(4, 1);
                for (int k = 0; k < nwords; k++) fifo_write(8'($urandom));
                fifo_burst($urandom_range(15, 0), $urandom_range(3, 0));
            end else begin
                cnt_burst($urandom_range(15, 0), $urandom_range(3, 0), $urandom_range(4, 1));
            end
        end

        fifo_write(8'hFF);
        fifo_write(8'h0F);
        len = 4'd8;
        par_sel = 2'b00;
        src_sel = 1'b0;
        pulse(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) bit_time(1'b0, 8'h00, r, t);
        check_val("pre_rst_rts", r, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_rts", rts, 0);
        check_val("mid_rst_txd", txd, 1);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_empty", fifo_empty, 1);
        check_val("mid_rst_full", fifo_full, 0);
        rst_n = 1'b1;
        model_q.delete();
        pat = 0;

        fifo_write(8'h3C);
        for (int k = 0; k < 3; k++) begin
            bit_time(1'b0, 8'h00, r, t);
            check_val("run_cleared", r, 0);
        end
        exp_words = model_q;
        build_exp(8, 0);
        pulse(1'b1, 1'b1);
        capture(-1, -1, 8'h00, exp_line.size() + 8);
        model_q.delete();
        pulse(1'b0, 1'b1);

        cnt_burst(8, 0, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
